t05_hdecode: RTL and testbench

T05_HDECODE -- requirements
Module: t05_hDecode

---
 rtl/t05_hdecode.sv | 259 +++++++++++++++++++++++++
 tb/tb_t05_hdecode.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_hdecode.sv
// t05_hdecode -- serial Huffman-tree decoder.
//
// Walks a binary code tree held in an external node SRAM, one code bit at a
// time, and emits one decoded character per leaf reached. Each node word is
// {idx[71:64], left[63:55], right[54:46], sum[45:0]}. A child code of 9'h180
// is NULL, bit8=1 selects an internal node at child[6:0], and bit8=0 is a
// leaf carrying the character in child[7:0].
//
// Ports
//   clk                     system clock, rising edge
//   rst_n                   asynchronous reset, active-high (1 = in reset)
//   en                      decode enable; 0 aborts and returns to IDLE
//   root_idx, sym_total     tree root address / character count, taken on start
//   bit_in/valid/ready      code-bit stream (valid/ready handshake)
//   rd_req, rd_addr         node-read request pulse and node address
//   rd_data, rd_done        node word and its completion strobe
//   char_out/valid/ready    decoded character stream (valid/ready handshake)
//   busy, dec_fin, err      status flags
//
// Build option
//   T05_HDECODE_ROOT_CACHE_EN  keep the first root node read in a local cache so
//                              every later symbol starts in BIT without
//                              re-reading the root. Undefined by default.
//
// state | meaning
// IDLE  | disabled or waiting for en; all handshakes idle
// FETCH | one-cycle rd_req for the current node address
// WAIT  | read outstanding; node word latched on rd_done
// BIT   | bit_ready=1; consume one code bit and follow the chosen child
// EMIT  | char_valid=1 until char_ready accepts the decoded character
// DONE  | all characters decoded; dec_fin=1 until en drops
// ERR   | NULL child, bad node index or tree too deep; err=1 until en drops

module t05_hdecode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [6:0]  root_idx,
    input  logic [15:0] sym_total,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic        rd_req,
    output logic [6:0]  rd_addr,
    input  logic [71:0] rd_data,
    input  logic        rd_done,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        dec_fin,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_BIT,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [8:0] CHILD_NULL = 9'h180;
    localparam logic [6:0] DEPTH_MAX  = 7'd127;

    state_t      state_q;
    state_t      state_nxt;

    logic [6:0]  addr_q;
    logic [6:0]  root_q;
    logic [15:0] total_q;
    logic [15:0] sym_cnt_q;
    logic [6:0]  depth_q;
    logic [71:0] node_q;
    logic [7:0]  char_q;

    logic [8:0]  child_sel;
    logic        child_null;
    logic        idx_ok;
    logic [15:0] sym_cnt_inc;
    logic        last_sym;
    logic [6:0]  depth_inc;
    logic        root_hit;

    // idx and sum fields are kept in the node register for completeness but
    // only the child fields steer the walk.
    logic        node_unused;
    assign node_unused = ^{node_q[71:64], node_q[45:0]};

    assign child_sel   = bit_in ? node_q[54:46] : node_q[63:55];
    assign child_null  = (child_sel == CHILD_NULL);
    assign idx_ok      = (rd_data[70:64] == addr_q);
    assign sym_cnt_inc = sym_cnt_q + 16'd1;
    assign last_sym    = (sym_cnt_inc == total_q);
    assign depth_inc   = depth_q + 7'd1;

    assign rd_addr  = addr_q;
    assign char_out = char_q;

`ifdef T05_HDECODE_ROOT_CACHE_EN
    logic [71:0] cache_q;
    logic        cache_vld_q;

    // Only a root read that passed the index check is cached; it is dropped
    // whenever the block sits in IDLE so a new tree can be loaded.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            cache_vld_q <= 1'b0;
        end else if (en && (state_q == ST_WAIT) && rd_done && idx_ok &&
                     (depth_q == 7'd0) && !cache_vld_q) begin
            cache_q     <= rd_data;
            cache_vld_q <= 1'b1;
        end
    end

    assign root_hit = cache_vld_q;
`else
    assign root_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        bit_ready  = 1'b0;
        rd_req     = 1'b0;
        char_valid = 1'b0;
        busy       = 1'b0;
        dec_fin    = 1'b0;
        err        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = (sym_total != 16'd0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                rd_req    = 1'b1;
                busy      = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (rd_done) begin
                    state_nxt = idx_ok ? ST_BIT : ST_ERR;
                end
            end
            ST_BIT: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
                if (bit_valid) begin
                    if (child_null) begin
                        state_nxt = ST_ERR;
                    end else if (child_sel[8]) begin
                        // Descending to depth 127 means no leaf can be reached.
                        state_nxt = (depth_inc == DEPTH_MAX) ? ST_ERR : ST_FETCH;
                    end else begin
                        state_nxt = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                char_valid = 1'b1;
                busy       = 1'b1;
                if (char_ready) begin
                    if (last_sym) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = root_hit ? ST_BIT : ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                dec_fin = 1'b1;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Dropping en overrides everything, including an outstanding read.
        if (!en) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            addr_q    <= '0;
            root_q    <= '0;
            total_q   <= '0;
            sym_cnt_q <= '0;
            depth_q   <= '0;
            node_q    <= '0;
            char_q    <= '0;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (sym_total != 16'd0) begin
                        addr_q    <= root_idx;
                        root_q    <= root_idx;
                        total_q   <= sym_total;
                        sym_cnt_q <= '0;
                        depth_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (rd_done) begin
                        node_q <= rd_data;
                    end
                end
                ST_BIT: begin
                    if (bit_valid && !child_null) begin
                        if (child_sel[8]) begin
                            if (depth_inc != DEPTH_MAX) begin
                                addr_q  <= child_sel[6:0];
                                depth_q <= depth_inc;
                            end
                        end else begin
                            char_q <= child_sel[7:0];
                        end
                    end
                end
                ST_EMIT: begin
                    if (char_ready) begin
                        sym_cnt_q <= sym_cnt_inc;
                        if (!last_sym) begin
                            addr_q  <= root_q;
                            depth_q <= '0;
`ifdef T05_HDECODE_ROOT_CACHE_EN
                            if (cache_vld_q) begin
                                node_q <= cache_q;
                            end
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t05_hdecode.sv
module tb_t05_hdecode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [6:0]  root_idx = '0;
    logic [15:0] sym_total = '0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic        rd_req;
    logic [6:0]  rd_addr;
    logic [71:0] rd_data = '0;
    logic        rd_done = 1'b0;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready = 1'b1;
    logic        busy;
    logic        dec_fin;
    logic        err;

`ifdef T05_HDECODE_ROOT_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    t05_hdecode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .root_idx   (root_idx),
        .sym_total  (sym_total),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_done    (rd_done),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .dec_fin    (dec_fin),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [71:0] mem [0:127];
    int          mem_lat = 1;
    logic [6:0]  req_log [$];
    logic        rsp_pend = 1'b0;
    logic [6:0]  rsp_addr = '0;
    int          rsp_cnt = 0;

    bit          bits_q [$];
    logic        br_q = 1'b0;

    logic [7:0]  exp_q [$];
    int          char_cnt = 0;
    logic        sink_stall = 1'b0;
    logic        cv_q = 1'b0;
    logic [7:0]  cout_q = '0;

    function automatic logic [71:0] node(input logic [7:0] idx,
                                         input logic [8:0] l,
                                         input logic [8:0] r);
        return {idx, l, r, 46'd0};
    endfunction

    // Node SRAM: logs each request, answers after mem_lat cycles.
    always @(negedge clk) begin
        rd_done = 1'b0;
        if (rst_n) begin
            rsp_pend = 1'b0;
        end else if (rd_req) begin
            req_log.push_back(rd_addr);
            rsp_pend = 1'b1;
            rsp_addr = rd_addr;
            rsp_cnt  = mem_lat;
        end else if (rsp_pend) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt <= 0) begin
                rd_done  = 1'b1;
                rd_data  = mem[rsp_addr];
                rsp_pend = 1'b0;
            end
        end
    end

    // Bit source: a bit leaves the queue once the edge after it saw ready.
    always @(negedge clk) begin
        if (bit_valid && br_q && bits_q.size() > 0) begin
            void'(bits_q.pop_front());
        end
        br_q = bit_ready;
        if (bits_q.size() > 0) begin
            bit_valid = 1'b1;
            bit_in    = bits_q[0];
        end else begin
            bit_valid = 1'b0;
            bit_in    = 1'b0;
        end
    end

    // Character sink and scoreboard check.
    always @(negedge clk) begin
        if (cv_q && char_ready) begin
            checks++;
            char_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL char_unexpected got %h expected none", cout_q);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (cout_q !== e) begin
                    errors++;
                    $display("FAIL char_value got %h expected %h", cout_q, e);
                end
            end
        end
        cv_q       = char_valid;
        cout_q     = char_out;
        char_ready = !sink_stall;
    end

    task automatic clear_tb();
        bits_q.delete();
        exp_q.delete();
        req_log.delete();
    endtask

    task automatic start(input logic [6:0] r, input logic [15:0] t);
        @(negedge clk);
        root_idx  = r;
        sym_total = t;
        en        = 1'b1;
    endtask

    task automatic wait_end(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (dec_fin || err) break;
        end
        @(negedge clk);
    endtask

    task automatic stop_dec();
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, dec_fin, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000", {busy, dec_fin, err});
        end
        checks++;
        if ({rd_req, rd_addr, bit_ready} !== 9'd0) begin
            errors++;
            $display("FAIL reset_rd got %b/%h/%b expected 0", rd_req, rd_addr, bit_ready);
        end
        checks++;
        if ({char_valid, char_out} !== 9'd0) begin
            errors++;
            $display("FAIL reset_char got %b/%h expected 0", char_valid, char_out);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while a read is outstanding.
        clear_tb();
        mem[5]  = node(8'h05, 9'h041, 9'h042);
        mem_lat = 8;
        start(7'd5, 16'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_log.size() != 0) break;
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        req_log.delete();
        repeat (12) @(negedge clk);
        checks++;
        if (req_log.size() != 0 || busy !== 1'b0 || rd_addr !== 7'd0) begin
            errors++;
            $display("FAIL reset_midread got reqs=%0d busy=%b addr=%h expected 0/0/0",
                     req_log.size(), busy, rd_addr);
        end
        mem_lat = 1;
    endtask

    task automatic test_basic();
        int base;
        int nreq;
        clear_tb();
        mem[5]  = node(8'h05, 9'h041, 9'h042);
        mem_lat = 1;
        bits_q  = '{0, 1, 1};
        exp_q   = '{8'h41, 8'h42, 8'h42};
        base    = char_cnt;
        start(7'd5, 16'd3);
        wait_end(300);
        checks++;
        if ({dec_fin, err, busy} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done got fin/err/busy=%b expected 100", {dec_fin, err, busy});
        end
        checks++;
        if (char_cnt - base != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count got %0d chars left=%0d expected 3/0",
                     char_cnt - base, exp_q.size());
        end
        nreq = CACHE_ON ? 1 : 3;
        checks++;
        if (req_log.size() != nreq) begin
            errors++;
            $display("FAIL basic_root_reads got %0d expected %0d", req_log.size(), nreq);
        end
        stop_dec();
        checks++;
        if (dec_fin !== 1'b0) begin
            errors++;
            $display("FAIL basic_fin_clear got %b expected 0", dec_fin);
        end
    endtask

    task automatic test_two_level();
        logic [6:0] a0;
        logic [6:0] a1;
        clear_tb();
        mem[5]  = node(8'h05, 9'h041, 9'h103);
        mem[3]  = node(8'h03, 9'h043, 9'h044);
        mem_lat = 2;
        bits_q  = '{1, 0};
        exp_q   = '{8'h43};
        start(7'd5, 16'd1);
        wait_end(300);
        a0 = (req_log.size() > 0) ? req_log[0] : 7'h7f;
        a1 = (req_log.size() > 1) ? req_log[1] : 7'h7f;
        checks++;
        if (req_log.size() != 2 || a0 !== 7'd5 || a1 !== 7'd3) begin
            errors++;
            $display("FAIL two_level_reads got n=%0d %h,%h expected 2 05,03",
                     req_log.size(), a0, a1);
        end
        checks++;
        if (dec_fin !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL two_level_done got fin=%b left=%0d expected 1/0", dec_fin, exp_q.size());
        end
        stop_dec();
        mem_lat = 1;
    endtask

    task automatic test_stall();
        int base;
        clear_tb();
        mem[5]     = node(8'h05, 9'h041, 9'h042);
        bits_q     = '{0, 1};
        exp_q      = '{8'h41, 8'h42};
        sink_stall = 1'b1;
        start(7'd5, 16'd2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (char_valid) break;
        end
        base = char_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({char_valid, char_out, bit_ready, busy} !== {1'b1, 8'h41, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got v=%b c=%h br=%b busy=%b expected 1/41/0/1",
                         i, char_valid, char_out, bit_ready, busy);
            end
        end
        checks++;
        if (char_cnt != base) begin
            errors++;
            $display("FAIL stall_count got %0d accepted expected 0", char_cnt - base);
        end
        sink_stall = 1'b0;
        wait_end(300);
        checks++;
        if (dec_fin !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_done got fin=%b left=%0d expected 1/0", dec_fin, exp_q.size());
        end
        stop_dec();
    endtask

    task automatic test_null();
        int base;
        clear_tb();
        mem[5] = node(8'h05, 9'h05A, 9'h180);
        bits_q = '{1};
        base   = char_cnt;
        start(7'd5, 16'd1);
        wait_end(300);
        checks++;
        if ({err, dec_fin, busy} !== 3'b100 || char_cnt != base) begin
            errors++;
            $display("FAIL null_err got err/fin/busy=%b chars=%0d expected 100/0",
                     {err, dec_fin, busy}, char_cnt - base);
        end
        stop_dec();
        checks++;
        if ({err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL null_clear got err/busy=%b expected 00", {err, busy});
        end
    endtask

    task automatic test_bad_idx();
        clear_tb();
        mem[5] = node(8'h05, 9'h041, 9'h103);
        mem[3] = node(8'h07, 9'h043, 9'h044);
        bits_q = '{1};
        start(7'd5, 16'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (rd_done && req_log.size() == 2) break;
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_idx_early got err=%b expected 0", err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bad_idx_err got err=%b expected 1", err);
        end
        stop_dec();
    endtask

    task automatic test_zero_total();
        clear_tb();
        start(7'd5, 16'd0);
        repeat (3) @(negedge clk);
        checks++;
        if ({dec_fin, busy} !== 2'b10 || req_log.size() != 0) begin
            errors++;
            $display("FAIL zero_total got fin/busy=%b reqs=%0d expected 10/0",
                     {dec_fin, busy}, req_log.size());
        end
        stop_dec();
    endtask

    task automatic test_depth();
        clear_tb();
        mem[5] = node(8'h05, 9'h105, 9'h105);
        for (int i = 0; i < 127; i++) bits_q.push_back(1'b0);
        start(7'd5, 16'd1);
        wait_end(3000);
        checks++;
        if (err !== 1'b1 || bits_q.size() != 0 || req_log.size() != 127) begin
            errors++;
            $display("FAIL depth_limit got err=%b bits_left=%0d reqs=%0d expected 1/0/127",
                     err, bits_q.size(), req_log.size());
        end
        stop_dec();
    endtask

    task automatic test_abort_wait();
        int base;
        int nreq;
        clear_tb();
        mem[5]  = node(8'h05, 9'h041, 9'h042);
        mem_lat = 6;
        bits_q  = '{0, 1};
        start(7'd5, 16'd2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_log.size() != 0) break;
        end
        @(negedge clk);
        en     = 1'b0;
        mem[5] = node(8'h05, 9'h180, 9'h180);
        repeat (10) @(negedge clk);
        checks++;
        if ({busy, err, dec_fin, char_valid, rd_req} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_idle got busy/err/fin/cv/req=%b expected 00000",
                     {busy, err, dec_fin, char_valid, rd_req});
        end
        mem[5]  = node(8'h05, 9'h041, 9'h042);
        mem_lat = 1;
        clear_tb();
        bits_q  = '{0, 1};
        exp_q   = '{8'h41, 8'h42};
        base    = char_cnt;
        start(7'd5, 16'd2);
        wait_end(300);
        checks++;
        if (dec_fin !== 1'b1 || exp_q.size() != 0 || char_cnt - base != 2) begin
            errors++;
            $display("FAIL abort_restart got fin=%b left=%0d chars=%0d expected 1/0/2",
                     dec_fin, exp_q.size(), char_cnt - base);
        end
        nreq = CACHE_ON ? 1 : 2;
        checks++;
        if (req_log.size() != nreq) begin
            errors++;
            $display("FAIL abort_root_reads got %0d expected %0d", req_log.size(), nreq);
        end
        stop_dec();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        #1 rst_n = 1'b1;
        test_reset();
        test_basic();
        test_two_level();
        test_stall();
        test_null();
        test_bad_idx();
        test_zero_total();
        test_depth();
        test_abort_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
